// File: rtl/multi_alarm_clock.sv
// Time-of-day clock, stopwatch and NUM_ALARMS alarm channels with snooze and
// auto-timeout. All state advances on a prescaled centisecond tick; the display
// and alarm outputs are registered from next-state values, so each new value
// appears in the cycle directly after the edge that produced it.
module multi_alarm_clock #(
  parameter int unsigned TICKS_PER_CS = 1,
  parameter int unsigned NUM_ALARMS   = 4,
  parameter int unsigned SNOOZE_SEC   = 300,
  parameter int unsigned RING_SEC     = 60
) (
  input  logic                          clk,
  input  logic                          global_reset,
  input  logic [1:0]                    mode,
  input  logic [1:0]                    select,
  input  logic                          increment,
  input  logic [$clog2(NUM_ALARMS)-1:0] alarm_sel,
  input  logic [NUM_ALARMS-1:0]         alarm_enable,
  input  logic                          snooze,
  input  logic                          dismiss,
  input  logic                          sw_clear,
  output logic [6:0]                    ms_out,
  output logic [5:0]                    sec_out,
  output logic [5:0]                    min_out,
  output logic [4:0]                    hour_out,
  output logic [NUM_ALARMS-1:0]         alarm_out,
  output logic                          alarm_any
);

  localparam int unsigned PreW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
  localparam logic [PreW-1:0] PreLast = PreW'(TICKS_PER_CS - 1);
  localparam logic [15:0] RingLoad   = 16'(RING_SEC);
  localparam logic [15:0] SnoozeLoad = 16'(SNOOZE_SEC);

  localparam logic [1:0] ModeClock     = 2'd0;
  localparam logic [1:0] ModeStopwatch = 2'd1;
  localparam logic [1:0] ModeAlarmEdit = 2'd2;
  localparam logic [1:0] ModeClockEdit = 2'd3;

  localparam logic [1:0] SelNone = 2'd0;
  localparam logic [1:0] SelSec  = 2'd1;
  localparam logic [1:0] SelMin  = 2'd2;
  localparam logic [1:0] SelHour = 2'd3;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] mn;
    logic [5:0] sc;
    logic [6:0] cs;
  } tod_t;

  typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} ch_state_e;

  function automatic logic [5:0] wrap60(logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] wrap24(logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // One centisecond step with full carry chain and day wrap.
  function automatic tod_t tod_inc(tod_t t);
    tod_t r;
    r = t;
    if (t.cs != 7'd99) begin
      r.cs = t.cs + 7'd1;
    end else begin
      r.cs = 7'd0;
      r.sc = wrap60(t.sc);
      if (t.sc == 6'd59) begin
        r.mn = wrap60(t.mn);
        if (t.mn == 6'd59) begin
          r.hr = wrap24(t.hr);
        end
      end
    end
    return r;
  endfunction

  // Single-field edit: wraps within the field, never carries.
  function automatic tod_t tod_edit(tod_t t, logic [1:0] sel);
    tod_t r;
    r = t;
    case (sel)
      SelSec: begin
        r.sc = wrap60(t.sc);
        r.cs = 7'd0;
      end
      SelMin:  r.mn = wrap60(t.mn);
      SelHour: r.hr = wrap24(t.hr);
      default: r = t;
    endcase
    return r;
  endfunction

  logic [PreW-1:0]       pre_q, pre_d;
  logic                  edit_hold, cs_tick, sec_roll;
  logic                  inc_q, inc_rise;
  logic                  sel_ok;
  tod_t                  clk_q, clk_d;
  tod_t                  sw_q, sw_d;
  logic                  sw_run_q, sw_run_d;
  tod_t                  disp_q, disp_d;
  tod_t                  alm_q [NUM_ALARMS];
  tod_t                  alm_d [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match;

  // The prescaler freezes with the clock during clock edit, so no tick fires there.
  assign edit_hold = (mode == ModeClockEdit);
  assign cs_tick   = (pre_q == PreLast) && !edit_hold;
  assign sec_roll  = cs_tick && (clk_q.cs == 7'd99);
  assign inc_rise  = increment & ~inc_q;
  assign sel_ok    = 32'(alarm_sel) < NUM_ALARMS;

  // Prescaler next state.
  always_comb begin
    pre_d = pre_q;
    if (!edit_hold) begin
      pre_d = (pre_q == PreLast) ? '0 : pre_q + PreW'(1);
    end
  end

  // Time-of-day next state: tick outside edit, single-field edits inside.
  always_comb begin
    clk_d = clk_q;
    if (cs_tick) begin
      clk_d = tod_inc(clk_q);
    end else if (edit_hold && inc_rise) begin
      clk_d = tod_edit(clk_q, select);
    end
  end

  // Stopwatch next state; clear beats toggle and tick, tick uses the old run flag.
  always_comb begin
    sw_d     = sw_q;
    sw_run_d = sw_run_q;
    if (sw_clear) begin
      sw_d     = '0;
      sw_run_d = 1'b0;
    end else begin
      if (sw_run_q && cs_tick) begin
        sw_d = tod_inc(sw_q);
      end
      if ((mode == ModeStopwatch) && inc_rise) begin
        sw_run_d = ~sw_run_q;
      end
    end
  end

  // Alarm time edits for the selected channel.
  always_comb begin
    for (int i = 0; i < NUM_ALARMS; i++) begin
      alm_d[i] = alm_q[i];
    end
    if ((mode == ModeAlarmEdit) && inc_rise && sel_ok) begin
      alm_d[alarm_sel] = tod_edit(alm_q[alarm_sel], select);
    end
  end

  // Match only on a timekeeping tick landing exactly on an alarm second.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      match[i] = cs_tick && (clk_d.cs == 7'd0) && (clk_d.hr == alm_q[i].hr) &&
                 (clk_d.mn == alm_q[i].mn) && (clk_d.sc == alm_q[i].sc);
    end
  end

  // Display source select from next-state values.
  always_comb begin
    disp_d = clk_d;
    unique case (mode)
      ModeClock, ModeClockEdit: disp_d = clk_d;
      ModeStopwatch:            disp_d = sw_d;
      ModeAlarmEdit: begin
        disp_d    = sel_ok ? alm_d[alarm_sel] : '0;
        disp_d.cs = 7'd0;
      end
      default: disp_d = clk_d;
    endcase
  end

  // Timekeeping, stopwatch, alarm-time and display registers.
  always_ff @(posedge clk) begin
    if (global_reset) begin
      pre_q    <= '0;
      inc_q    <= 1'b0;
      clk_q    <= '0;
      sw_q     <= '0;
      sw_run_q <= 1'b0;
      disp_q   <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_q[i] <= '0;
      end
    end else begin
      pre_q    <= pre_d;
      inc_q    <= increment;
      clk_q    <= clk_d;
      sw_q     <= sw_d;
      sw_run_q <= sw_run_d;
      disp_q   <= disp_d;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alm_q[i] <= alm_d[i];
      end
    end
  end

  assign ms_out   = disp_q.cs;
  assign sec_out  = disp_q.sc;
  assign min_out  = disp_q.mn;
  assign hour_out = disp_q.hr;

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_chan
    ch_state_e   st_q;
    logic [15:0] ring_q;
    logic [15:0] snz_q;
    logic        out_q;

    // Ring FSM; out_q tracks the next state so it lines up with the display.
    always_ff @(posedge clk) begin
      if (global_reset) begin
        st_q   <= StIdle;
        ring_q <= '0;
        snz_q  <= '0;
        out_q  <= 1'b0;
      end else if (!alarm_enable[i]) begin
        st_q  <= StIdle;
        out_q <= 1'b0;
      end else begin
        unique case (st_q)
          StIdle: begin
            if (match[i]) begin
              st_q   <= StRinging;
              ring_q <= RingLoad;
              out_q  <= 1'b1;
            end else begin
              out_q <= 1'b0;
            end
          end
          StRinging: begin
            if (dismiss) begin
              st_q  <= StIdle;
              out_q <= 1'b0;
            end else if (snooze) begin
              st_q  <= StSnoozed;
              snz_q <= SnoozeLoad;
              out_q <= 1'b0;
            end else if (sec_roll && (ring_q <= 16'd1)) begin
              st_q  <= StIdle;
              out_q <= 1'b0;
            end else if (match[i]) begin
              ring_q <= RingLoad;
              out_q  <= 1'b1;
            end else begin
              if (sec_roll) begin
                ring_q <= ring_q - 16'd1;
              end
              out_q <= 1'b1;
            end
          end
          StSnoozed: begin
            if (dismiss) begin
              st_q  <= StIdle;
              out_q <= 1'b0;
            end else if (sec_roll && (snz_q <= 16'd1)) begin
              st_q   <= StRinging;
              ring_q <= RingLoad;
              out_q  <= 1'b1;
            end else begin
              if (sec_roll) begin
                snz_q <= snz_q - 16'd1;
              end
              out_q <= 1'b0;
            end
          end
          default: begin
            st_q  <= StIdle;
            out_q <= 1'b0;
          end
        endcase
      end
    end

    assign alarm_out[i] = out_q;
  end

  assign alarm_any = |alarm_out;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Scoreboarded bench: the driver steps a centisecond-of-day reference model each
// cycle and queues the expected outputs; a monitor compares after every edge.
module tb_multi_alarm_clock;

  localparam int T   = 2;
  localparam int NA  = 4;
  localparam int SNZ = 2;
  localparam int RNG = 2;
  localparam int DAY = 8640000;

  logic          clk = 1'b0;
  logic          global_reset = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [1:0]    select = 2'd0;
  logic          increment = 1'b0;
  logic [1:0]    alarm_sel = 2'd0;
  logic [NA-1:0] alarm_enable = '0;
  logic          snooze = 1'b0;
  logic          dismiss = 1'b0;
  logic          sw_clear = 1'b0;
  logic [6:0]    ms_out;
  logic [5:0]    sec_out;
  logic [5:0]    min_out;
  logic [4:0]    hour_out;
  logic [NA-1:0] alarm_out;
  logic          alarm_any;

  always #5 clk = ~clk;

  multi_alarm_clock #(
    .TICKS_PER_CS(T),
    .NUM_ALARMS  (NA),
    .SNOOZE_SEC  (SNZ),
    .RING_SEC    (RNG)
  ) dut (
    .clk         (clk),
    .global_reset(global_reset),
    .mode        (mode),
    .select      (select),
    .increment   (increment),
    .alarm_sel   (alarm_sel),
    .alarm_enable(alarm_enable),
    .snooze      (snooze),
    .dismiss     (dismiss),
    .sw_clear    (sw_clear),
    .ms_out      (ms_out),
    .sec_out     (sec_out),
    .min_out     (min_out),
    .hour_out    (hour_out),
    .alarm_out   (alarm_out),
    .alarm_any   (alarm_any)
  );

  int errors = 0;
  int checks = 0;
  logic [28:0] exp_q[$];
  logic [28:0] got, want;

  // Reference model: times held as centiseconds of the day.
  int m_clk, m_sw, m_pre;
  bit m_prev, m_run;
  int m_alm[NA];
  int m_st[NA];  // 0 idle, 1 ringing, 2 snoozed
  int m_ring[NA];
  int m_snz[NA];

  function automatic int bump(int t, logic [1:0] sel);
    int h, m, s, c;
    h = t / 360000;
    m = (t / 6000) % 60;
    s = (t / 100) % 60;
    c = t % 100;
    case (sel)
      2'd1: begin s = (s + 1) % 60; c = 0; end
      2'd2: m = (m + 1) % 60;
      2'd3: h = (h + 1) % 24;
      default: ;
    endcase
    return h * 360000 + m * 6000 + s * 100 + c;
  endfunction

  function automatic logic [28:0] pack(int t, logic [NA-1:0] ao);
    return {7'(t % 100), 6'((t / 100) % 60), 6'((t / 6000) % 60), 5'(t / 360000), ao, |ao};
  endfunction

  task automatic model_step();
    bit tick, roll, rise;
    bit [NA-1:0] hit;
    logic [NA-1:0] ao;
    int disp;
    if (global_reset) begin
      m_clk = 0; m_sw = 0; m_pre = 0; m_prev = 0; m_run = 0;
      for (int i = 0; i < NA; i++) begin
        m_alm[i] = 0; m_st[i] = 0; m_ring[i] = 0; m_snz[i] = 0;
      end
      exp_q.push_back('0);
      return;
    end
    tick = (mode != 2'd3) && (m_pre == T - 1);
    if (mode != 2'd3) m_pre = (m_pre + 1) % T;
    rise = increment && !m_prev;
    m_prev = increment;
    roll = 0;
    hit = '0;
    if (tick) begin
      m_clk = (m_clk + 1) % DAY;
      roll = (m_clk % 100 == 0);
      for (int i = 0; i < NA; i++) hit[i] = (m_clk == m_alm[i]);
    end else if (mode == 2'd3 && rise) begin
      m_clk = bump(m_clk, select);
    end
    if (mode == 2'd2 && rise && int'(alarm_sel) < NA) m_alm[alarm_sel] = bump(m_alm[alarm_sel], select);
    if (sw_clear) begin
      m_sw = 0;
      m_run = 0;
    end else begin
      if (m_run && tick) m_sw = (m_sw + 1) % DAY;
      if (mode == 2'd1 && rise) m_run = !m_run;
    end
    for (int i = 0; i < NA; i++) begin
      if (!alarm_enable[i]) m_st[i] = 0;
      else if (m_st[i] == 0) begin
        if (hit[i]) begin m_st[i] = 1; m_ring[i] = RNG; end
      end else if (m_st[i] == 1) begin
        if (dismiss) m_st[i] = 0;
        else if (snooze) begin m_st[i] = 2; m_snz[i] = SNZ; end
        else if (roll && m_ring[i] <= 1) m_st[i] = 0;
        else if (hit[i]) m_ring[i] = RNG;
        else if (roll) m_ring[i]--;
      end else begin
        if (dismiss) m_st[i] = 0;
        else if (roll && m_snz[i] <= 1) begin m_st[i] = 1; m_ring[i] = RNG; end
        else if (roll) m_snz[i]--;
      end
      ao[i] = (m_st[i] == 1);
    end
    case (mode)
      2'd1: disp = m_sw;
      2'd2: disp = (int'(alarm_sel) < NA) ? m_alm[alarm_sel] : 0;
      default: disp = m_clk;
    endcase
    exp_q.push_back(pack(disp, ao));
  endtask

  // Monitor: one scoreboard comparison after every edge with a queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      want = exp_q.pop_front();
      got = {ms_out, sec_out, min_out, hour_out, alarm_out, alarm_any};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL scoreboard @%0t: got %0d:%0d:%0d.%0d ao=%b any=%b expected %0d:%0d:%0d.%0d ao=%b any=%b",
                 $time, got[9:5], got[15:10], got[21:16], got[28:22], got[4:1], got[0],
                 want[9:5], want[15:10], want[21:16], want[28:22], want[4:1], want[0]);
      end
    end
  end

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic rst();
    global_reset = 1'b1;
    cyc();
    global_reset = 1'b0;
  endtask

  task automatic pulse_inc(int n);
    for (int k = 0; k < n; k++) begin
      increment = 1'b1;
      cyc();
      increment = 1'b0;
      cyc();
    end
  endtask

  task automatic set_alarm_sec(int ch, int n);
    mode = 2'd2;
    alarm_sel = 2'(ch);
    select = 2'd1;
    pulse_inc(n);
    select = 2'd0;
  endtask

  task automatic wait_ring();
    for (int k = 0; k < 1500 && alarm_out == 0; k++) cyc();
    chk("ring_seen", int'(alarm_out != 0), 1);
  endtask

  task automatic arm_ch2();
    rst();
    set_alarm_sec(2, 3);
    mode = 2'd0;
    alarm_enable = 4'b0100;
    wait_ring();
  endtask

  initial begin
    // Reset state
    rst();
    run(1);
    chk("reset_time", {ms_out, sec_out, min_out, hour_out}, 0);
    chk("reset_alarm", alarm_out, 0);

    // One minute of ticks from reset
    rst();
    run(12000);
    chk("minute_min", min_out, 1);
    chk("minute_sec", sec_out, 0);
    chk("minute_ms", ms_out, 0);

    // Day wrap 23:59:59.00 + 1 s
    mode = 2'd3;
    select = 2'd3; pulse_inc(23);
    select = 2'd2; pulse_inc(58);
    select = 2'd1; pulse_inc(59);
    chk("edit_to_2359", hour_out * 10000 + min_out * 100 + sec_out, 235959);
    mode = 2'd0;
    run(200);
    chk("day_wrap", {ms_out, sec_out, min_out, hour_out}, 0);

    // Hour edit wraps without carry; clock frozen; held level edits once
    mode = 2'd3;
    select = 2'd3;
    pulse_inc(25);
    chk("edit_hour25", hour_out, 1);
    chk("edit_min_kept", min_out, 0);
    run(20);
    chk("edit_frozen", ms_out + sec_out * 100, 0);
    increment = 1'b1;
    run(10);
    increment = 1'b0;
    cyc();
    chk("edit_held_once", hour_out, 2);

    // Alarm on channel 2 at 00:00:03
    rst();
    set_alarm_sec(2, 3);
    chk("alarm_edit_disp", sec_out, 3);
    mode = 2'd0;
    alarm_enable = 4'b0100;
    wait_ring();
    chk("ring_vec", alarm_out, 4);
    chk("ring_at", sec_out * 100 + ms_out, 300);
    run(50);
    alarm_enable = 4'b0000;
    cyc();
    chk("disable_clears", alarm_out, 0);

    // Snooze then re-ring two second-rollovers later; dismiss beats snooze
    arm_ch2();
    run(20);
    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snoozed", alarm_out, 0);
    for (int k = 0; k < 1000 && alarm_out == 0; k++) cyc();
    chk("rering_at", sec_out * 100 + ms_out, 500);
    chk("rering_vec", alarm_out, 4);
    run(10);
    dismiss = 1'b1; snooze = 1'b1; cyc(); dismiss = 1'b0; snooze = 1'b0;
    chk("dismiss_snooze", alarm_out, 0);
    run(600);
    chk("stays_idle", alarm_out, 0);

    // Auto-timeout after RING_SEC rollovers
    arm_ch2();
    for (int k = 0; k < 1000 && alarm_out != 0; k++) cyc();
    chk("timeout_at", sec_out * 100 + ms_out, 500);
    chk("timeout_vec", alarm_out, 0);

    // Reset while ringing
    arm_ch2();
    global_reset = 1'b1; cyc(); global_reset = 1'b0;
    chk("reset_mid_ring", {ms_out, sec_out, min_out, hour_out, alarm_out, alarm_any}, 0);
    alarm_enable = '0;

    // Stopwatch
    rst();
    mode = 2'd1;
    increment = 1'b1; cyc(); increment = 1'b0;
    run(300);
    chk("sw_150", sec_out * 100 + ms_out, 150);
    mode = 2'd0;
    run(200);
    mode = 2'd1;
    run(2);
    chk("sw_keeps_running", sec_out * 100 + ms_out, 251);
    sw_clear = 1'b1; cyc(); sw_clear = 1'b0;
    chk("sw_clear", {ms_out, sec_out, min_out, hour_out}, 0);
    run(20);
    chk("sw_paused", {ms_out, sec_out}, 0);

    // Randomized traffic with alarms near the start of the day
    rst();
    set_alarm_sec(0, 2);
    set_alarm_sec(1, 4);
    set_alarm_sec(2, 4);
    set_alarm_sec(3, 7);
    mode = 2'd0;
    alarm_enable = '1;
    for (int k = 0; k < 6000; k++) begin
      if ($urandom_range(0, 999) < 20) begin
        int r;
        r = int'($urandom_range(0, 99));
        mode = (r < 50) ? 2'd0 : (r < 75) ? 2'd1 : (r < 90) ? 2'd2 : 2'd3;
      end
      if ($urandom_range(0, 99) < 10) increment = ~increment;
      if ($urandom_range(0, 99) < 5) select = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 5) alarm_sel = 2'($urandom_range(0, 3));
      for (int i = 0; i < NA; i++) begin
        if ($urandom_range(0, 999) < 5) alarm_enable[i] = ~alarm_enable[i];
      end
      snooze   = ($urandom_range(0, 999) < 10);
      dismiss  = ($urandom_range(0, 999) < 5);
      sw_clear = ($urandom_range(0, 999) < 5);
      cyc();
    end
    snooze = 1'b0; dismiss = 1'b0; sw_clear = 1'b0; increment = 1'b0;
    run(2);
    #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
